cpu_mode_ctrl: RTL and testbench
================================

// Module: cpu_mode_ctrl
// PURPOSE
// - Front-panel mode sequencer directly upstream of the control unit; sole source of cpustate[1:0].
// - Steps the CPU through IDLE -> IN (program entry) -> CHECK (memory readback) -> RUN.
// - Drives the memory port from switches in IN/CHECK; releases the port to the datapath in RUN.
// - Control unit is held in reset unless cpustate==RUN.
// PARAMETERS
// - ADDR_W       8  memory address width; address counter width
// - DATA_W       8  memory data / switch width
// - SYNC_STAGES  2  synchronizer flops per push-button input (>=2)
// PORTS
// - clk        in   1       system clock, rising edge
// - reset      in   1       asynchronous, active-low
// - mode_btn   in   1       raw push button: advance mode
// - step_btn   in   1       raw push button: write (IN) / next address (CHECK)
// - sw_data    in   DATA_W  switch data for program entry
// - cpu_halt   in   1       one-cycle halt pulse from datapath, valid in RUN only
// - cpustate   out  2       00 IDLE, 01 IN, 10 CHECK, 11 RUN
// - mem_addr   out  ADDR_W  panel address; equals addr_cnt
// - mem_wdata  out  DATA_W  = sw_data, registered with the write strobe
// - mem_we     out  1       one-cycle panel write strobe
// - mem_re     out  1       panel read enable, high for the whole CHECK state
// - panel_own  out  1       1 = panel owns memory port, 0 = datapath owns it (RUN)
// - addr_wrap  out  1       sticky: addr_cnt wrapped max->0 in current IN/CHECK session
// BEHAVIOUR
// - Reset (async, reset=0): cpustate=00, addr_cnt=0, mem_we=0, mem_re=0, mem_wdata=0,
//   panel_own=1, addr_wrap=0. All synchronizer and edge flops cleared.
// - Each button passes through SYNC_STAGES flops and a rising-edge detector.
//   Output is a 1-cycle pulse (mode_p, step_p) per press. Button held high gives one pulse only.
// - Latency: with SYNC_STAGES=2, the pulse is high in the 3rd cycle after the raw edge.
//   The state/counter update lands on the following clk edge.
// - FSM transitions on mode_p:
//   - IDLE -> IN -> CHECK -> RUN -> IDLE.
//   - cpu_halt in RUN -> IDLE.
//   - mode_p and cpu_halt in the same cycle in RUN: -> IDLE, taken once.
//   - cpu_halt outside RUN is ignored.
// - Entering IN or CHECK: addr_cnt <= 0, addr_wrap <= 0.
// - IN, on step_p:
//   - mem_we=1 for exactly the next cycle; mem_addr=addr_cnt and mem_wdata=sw_data captured at step_p.
//   - addr_cnt increments on the edge ending the write cycle.
// - CHECK:
//   - mem_re=1 continuously.
//   - step_p: addr_cnt <= addr_cnt+1; read data is valid 1 cycle after the address changes.
// - Address wrap: 2^ADDR_W-1 + 1 -> 0 (modulo ADDR_W bits); addr_wrap <= 1 and stays set until the next IN/CHECK entry.
// - mode_p and step_p in the same cycle: mode wins; the step is dropped (no write, no increment).
// - Mode change during a write cycle: the mem_we cycle completes, then addr_cnt follows the new-state entry rule.
// - RUN: panel_own=0, mem_we=0, mem_re=0; addr_cnt frozen; step_p ignored.
// - IDLE: panel_own=1, no memory strobes, step_p ignored.
// - Async reset in any state, including mid-write: all outputs go to reset values immediately; mem_we drops.
// STRUCTURE
// - Shared package cpu_pkg:
//   - state codes ST_IDLE=2'b00, ST_IN=2'b01, ST_CHECK=2'b10, ST_RUN=2'b11.
//   - These codes are also used by the control unit's RUN-gated reset.
// - Sub-module btn_sync_edge (params SYNC_STAGES; ports clk, reset, btn_raw, pulse), instantiated twice.
// - Top level: FSM register, addr_cnt, write-strobe register, output decode.
// TESTING
// - Reset release, no buttons -> cpustate=00, panel_own=1, mem_we=0, mem_addr=0 for 20 cycles.
// - 4 mode presses (held 10 cycles each) -> cpustate 01,10,11,00. Exactly one transition per press.
//   Transition occurs 3 cycles after the raw edge.
// - IN, sw_data=8'hA5, step, then 8'h3C, step -> mem_we pulses at addr 0 (A5) and addr 1 (3C).
//   Each pulse is 1 cycle wide; addr_cnt=2 afterwards.
// - CHECK, 256 step presses -> mem_re=1 throughout; addr returns to 0; addr_wrap=1 after the 256th press.
// - RUN plus cpu_halt pulse -> cpustate=00 next edge. mode_p and step_p coincident in IN -> state=CHECK,
//   no mem_we, addr_cnt=0.
// - reset asserted during a mem_we cycle -> mem_we=0 and cpustate=00 without a clk edge.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cpu_pkg                                                   |
// | Brief    : Shared CPU mode codes and mode-advance helper             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package cpu_pkg;

  // Mode codes; the control unit decodes ST_RUN to release its reset
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_IN    = 2'b01,
    ST_CHECK = 2'b10,
    ST_RUN   = 2'b11
  } cpu_state_e;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;

  // Mode button cycles IDLE -> IN -> CHECK -> RUN -> IDLE
  function automatic cpu_state_e next_mode(input cpu_state_e s);
    cpu_state_e n;
    case (s)
      ST_IDLE:  n = ST_IN;
      ST_IN:    n = ST_CHECK;
      ST_CHECK: n = ST_RUN;
      default:  n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : btn_sync_edge                                             |
// | Brief    : Push-button synchronizer + registered rising-edge pulse   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   pulse_q, pulse_d;

  // Shift the raw button in; pulse only when the synced level first goes high
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw};
    edge_d  = sync_q[SYNC_STAGES-1];
    pulse_d = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  // Synchronizer, edge history and pulse flops, all cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/cpu_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cpu_mode_ctrl                                             |
// | Brief    : Front-panel mode sequencer and panel memory-port driver   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module cpu_mode_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_btn,
  input  logic              step_btn,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              cpu_halt,
  output logic [1:0]        cpustate,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              panel_own,
  output logic              addr_wrap
);

  logic mode_p;
  logic step_p;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode_sync (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (mode_btn),
    .pulse   (mode_p)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (step_btn),
    .pulse   (step_p)
  );

  cpu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              wrap_q, wrap_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              re_q, re_d;
  logic              own_q, own_d;
  logic              entering;
  logic              advance;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Next-state, address counter, write strobe and output decode
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    wrap_d     = wrap_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;

    // Mode press wins; a halt in RUN coincident with it still lands in IDLE once
    if (mode_p) begin
      state_d = next_mode(state_q);
    end else if ((state_q == ST_RUN) && cpu_halt) begin
      state_d = ST_IDLE;
    end

    // Write strobe is only launched by an undisturbed step press in IN
    if (!mode_p && (state_q == ST_IN) && step_p) begin
      we_d    = 1'b1;
      wdata_d = sw_data;
    end

    entering = (state_d != state_q) &&
               ((state_d == ST_IN) || (state_d == ST_CHECK));
    // IN advances at the end of its write cycle; CHECK advances on the step itself
    advance  = we_q || (!mode_p && (state_q == ST_CHECK) && step_p);

    if (entering) begin
      addr_cnt_d = '0;
      wrap_d     = 1'b0;
    end else if (advance) begin
      addr_cnt_d = addr_cnt_q + ADDR_ONE;
      if (addr_cnt_q == '1) begin
        wrap_d = 1'b1;
      end
    end

    // Port outputs are registered from the next state so they switch with cpustate
    re_d  = (state_d == ST_CHECK);
    own_d = (state_d != ST_RUN);
  end

  // Mode register and all registered panel outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_cnt_q <= '0;
      wrap_q     <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      re_q       <= 1'b0;
      own_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      wrap_q     <= wrap_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      re_q       <= re_d;
      own_q      <= own_d;
    end
  end

  assign cpustate  = state_q;
  assign mem_addr  = addr_cnt_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign panel_own = own_q;
  assign addr_wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_cpu_mode_ctrl                                          |
// | Brief    : Directed self-checking bench for cpu_mode_ctrl            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_cpu_mode_ctrl;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       mode_btn = 1'b0;
  logic       step_btn = 1'b0;
  logic       cpu_halt = 1'b0;
  logic [7:0] sw_data  = 8'h00;

  logic [1:0] cpustate;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic       panel_own;
  logic       addr_wrap;

  int total = 0;
  int bad   = 0;
  int re_low_seen;
  int we_seen;

  always #5 clk = ~clk;

  cpu_mode_ctrl #(.ADDR_W(8), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_btn  (mode_btn),
    .step_btn  (step_btn),
    .sw_data   (sw_data),
    .cpu_halt  (cpu_halt),
    .cpustate  (cpustate),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .panel_own (panel_own),
    .addr_wrap (addr_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Mode press held 10 cycles: state must stay put for 3 edges, change on the 4th, then hold
  task automatic mode_press(input logic [1:0] from_s, input logic [1:0] to_s, input string tag);
    @(negedge clk) mode_btn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) chk($sformatf("%s_early", tag), cpustate, from_s);
    @(posedge clk);
    @(negedge clk) chk($sformatf("%s_edge", tag), cpustate, to_s);
    repeat (6) @(negedge clk);
    mode_btn = 1'b0;
    repeat (4) @(negedge clk);
    chk($sformatf("%s_once", tag), cpustate, to_s);
  endtask

  // One program-entry write in IN with timing of the strobe and address
  task automatic write_step(input logic [7:0] data, input logic [7:0] exp_addr, input string tag);
    @(negedge clk) begin sw_data = data; step_btn = 1'b1; end
    repeat (3) @(posedge clk);
    @(negedge clk) chk($sformatf("%s_we_early", tag), mem_we, 1'b0);
    @(posedge clk);
    @(negedge clk) chk($sformatf("%s_we_cycle", tag), {mem_we, mem_addr, mem_wdata}, {1'b1, exp_addr, data});
    sw_data = ~data;
    @(posedge clk);
    @(negedge clk) chk($sformatf("%s_after", tag), {mem_we, mem_addr}, {1'b0, exp_addr + 8'd1});
    repeat (5) @(negedge clk);
    step_btn = 1'b0;
    repeat (4) @(negedge clk);
    chk($sformatf("%s_single", tag), {mem_we, mem_addr}, {1'b0, exp_addr + 8'd1});
  endtask

  // Fast step press in CHECK, watching mem_re every cycle
  task automatic check_step();
    step_btn = 1'b1;
    @(negedge clk) if (mem_re !== 1'b1) re_low_seen++;
    @(negedge clk) if (mem_re !== 1'b1) re_low_seen++;
    step_btn = 1'b0;
    @(negedge clk) if (mem_re !== 1'b1) re_low_seen++;
    @(negedge clk) if (mem_re !== 1'b1) re_low_seen++;
  endtask

  initial begin
    // Reset entry and release
    #2 reset = 1'b0;
    #1 chk("reset_state", {cpustate, panel_own, mem_we, mem_re, addr_wrap, mem_addr, mem_wdata},
           {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Quiet IDLE for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_hold", {cpustate, panel_own, mem_we, mem_re, addr_wrap, mem_addr},
          {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    end

    // Full mode cycle
    mode_press(2'b00, 2'b01, "m_in");
    chk("in_port", {panel_own, mem_re, mem_addr}, {1'b1, 1'b0, 8'h00});
    mode_press(2'b01, 2'b10, "m_check");
    chk("check_port", {panel_own, mem_re}, {1'b1, 1'b1});
    mode_press(2'b10, 2'b11, "m_run");
    chk("run_port", {panel_own, mem_re, mem_we}, {1'b0, 1'b0, 1'b0});
    mode_press(2'b11, 2'b00, "m_idle");
    chk("idle_port", {panel_own, mem_re}, {1'b1, 1'b0});

    // Program entry
    mode_press(2'b00, 2'b01, "p_in");
    write_step(8'hA5, 8'h00, "wr_a5");
    write_step(8'h3C, 8'h01, "wr_3c");
    chk("in_addr_2", mem_addr, 8'h02);

    // Readback with full address wrap
    mode_press(2'b01, 2'b10, "p_check");
    chk("check_entry", {mem_addr, addr_wrap, mem_re}, {8'h00, 1'b0, 1'b1});
    re_low_seen = 0;
    @(negedge clk);
    for (int i = 0; i < 255; i++) check_step();
    chk("addr_255", {mem_addr, addr_wrap}, {8'hFF, 1'b0});
    check_step();
    chk("addr_wrap", {mem_addr, addr_wrap}, {8'h00, 1'b1});
    for (int i = 0; i < 3; i++) check_step();
    chk("addr_3", {mem_addr, addr_wrap}, {8'h03, 1'b1});
    chk("re_steady", re_low_seen, 0);

    // RUN: port released, counter frozen, steps ignored, halt returns to IDLE
    mode_press(2'b10, 2'b11, "p_run");
    chk("run_frozen", {panel_own, mem_re, mem_addr, addr_wrap}, {1'b0, 1'b0, 8'h03, 1'b1});
    we_seen = 0;
    @(negedge clk) step_btn = 1'b1;
    repeat (8) @(negedge clk) if (mem_we !== 1'b0) we_seen++;
    step_btn = 1'b0;
    repeat (4) @(negedge clk) if (mem_we !== 1'b0) we_seen++;
    chk("run_step_ignored", {cpustate, mem_addr, we_seen[7:0]}, {2'b11, 8'h03, 8'h00});
    @(negedge clk) cpu_halt = 1'b1;
    @(negedge clk) cpu_halt = 1'b0;
    chk("halt_to_idle", {cpustate, panel_own}, {2'b00, 1'b1});

    // Halt and steps outside RUN are ignored
    cpu_halt = 1'b1;
    @(negedge clk) cpu_halt = 1'b0;
    @(negedge clk) step_btn = 1'b1;
    repeat (8) @(negedge clk);
    step_btn = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_ignore", {cpustate, mem_addr, mem_we}, {2'b00, 8'h03, 1'b0});

    // Coincident mode and step in IN: mode wins, no write
    mode_press(2'b00, 2'b01, "c_in");
    chk("c_in_entry", {mem_addr, addr_wrap}, {8'h00, 1'b0});
    write_step(8'h77, 8'h00, "wr_77");
    we_seen = 0;
    @(negedge clk) begin mode_btn = 1'b1; step_btn = 1'b1; end
    repeat (10) @(negedge clk) if (mem_we !== 1'b0) we_seen++;
    mode_btn = 1'b0;
    step_btn = 1'b0;
    repeat (4) @(negedge clk) if (mem_we !== 1'b0) we_seen++;
    chk("coincident", {cpustate, mem_addr, we_seen[7:0]}, {2'b10, 8'h00, 8'h00});

    // Mode change during the write cycle: write completes, then CHECK entry zeroes addr
    mode_press(2'b10, 2'b11, "d_run");
    mode_press(2'b11, 2'b00, "d_idle");
    mode_press(2'b00, 2'b01, "d_in");
    write_step(8'h11, 8'h00, "wr_11");
    @(negedge clk) begin sw_data = 8'h22; step_btn = 1'b1; end
    @(negedge clk) mode_btn = 1'b1;
    repeat (3) @(negedge clk);
    chk("mw_write", {cpustate, mem_we, mem_addr, mem_wdata}, {2'b01, 1'b1, 8'h01, 8'h22});
    @(negedge clk);
    chk("mw_after", {cpustate, mem_we, mem_addr}, {2'b10, 1'b0, 8'h00});
    repeat (8) @(negedge clk);
    mode_btn = 1'b0;
    step_btn = 1'b0;
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of a write cycle
    mode_press(2'b10, 2'b11, "r_run");
    mode_press(2'b11, 2'b00, "r_idle");
    mode_press(2'b00, 2'b01, "r_in");
    @(negedge clk) begin sw_data = 8'h5A; step_btn = 1'b1; end
    repeat (4) @(negedge clk);
    chk("rst_pre_we", mem_we, 1'b1);
    #1 reset = 1'b0;
    #1 chk("rst_async", {cpustate, panel_own, mem_we, mem_re, addr_wrap, mem_addr, mem_wdata},
           {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
    step_btn = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_settle", {cpustate, mem_we, mem_addr}, {2'b00, 1'b0, 8'h00});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
